// File: rtl/tick_timer_pkg.sv
// Shared types, BCD limits and the load legality check for the MM:SS tick timer.
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
  localparam logic [7:0] SEC_MAX_BIN   = 8'd59;

  // True when both digits are decimal and the pair does not exceed max_bin.
  function automatic logic bcd_legal(input logic [7:0] bcd, input logic [7:0] max_bin);
    logic [7:0] bin;
    bin = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
    return (bcd[7:4] <= BCD_DIGIT_MAX) && (bcd[3:0] <= BCD_DIGIT_MAX) && (bin <= max_bin);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter, modulus MODULUS (2..100), with clear and parallel load.
module bcd_mod_counter
  import tick_timer_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] val,
  output logic       carry,
  output logic       borrow
);

  localparam logic [3:0] TOP_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] TOP_ONES = 4'((MODULUS - 1) % 10);

  logic [3:0] tens_q, ones_q;
  logic [3:0] tens_d, ones_d;
  logic       at_top, at_zero;

  assign at_top  = (tens_q == TOP_TENS) && (ones_q == TOP_ONES);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Terminal flags: the next inc carries out / the next dec borrows out.
  assign carry  = at_top;
  assign borrow = at_zero;
  assign val    = {tens_q, ones_q};

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (load) begin
      tens_d = load_val[7:4];
      ones_d = load_val[3:0];
    end else if (inc) begin
      if (at_top) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == BCD_DIGIT_MAX) begin
        tens_d = tens_q + 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        tens_d = TOP_TENS;
        ones_d = TOP_ONES;
      end else if (ones_q == 4'd0) begin
        tens_d = tens_q - 4'd1;
        ones_d = BCD_DIGIT_MAX;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/tick_bcd_timer.sv
// BCD MM:SS up/down timer stepped by rising edges of the generator tick.
// Define TICK_SYNC_EN to place a two-flop synchronizer ahead of the edge detector.
module tick_bcd_timer
  import tick_timer_pkg::*;
#(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic       count_down,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       tick_en,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam logic [7:0] MAX_MIN_BIN = 8'(MAX_MIN);

  logic   tick_in, tick_q, tick_evt;
  state_t state_q, state_d;
  logic   dir_q, dir_d;
  logic   done_q, done_d;
  logic   load_err_q, load_err_d;
  logic   cnt_clr, cnt_load, sec_inc, sec_dec;
  logic   sec_carry, sec_borrow, min_carry, min_borrow;
  logic   load_ok, count_zero;

`ifdef TICK_SYNC_EN
  logic tick_p0, tick_p1;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      tick_p0 <= tick;
      tick_p1 <= tick_p0;
    end
  end

  assign tick_in = tick_p1;
`else
  assign tick_in = tick;
`endif

  // tick_q tracks in every state, so an edge seen while stopped never fires later.
  assign tick_evt   = tick_in & ~tick_q;
  assign count_zero = sec_borrow & min_borrow;
  assign load_ok    = bcd_legal(load_min, MAX_MIN_BIN) && bcd_legal(load_sec, SEC_MAX_BIN) &&
                      (load_sec[7:4] <= SEC_TENS_MAX);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    sec_inc    = 1'b0;
    sec_dec    = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else if (load && (state_q != RUN)) begin
      if (load_ok) cnt_load = 1'b1;
      else         load_err_d = 1'b1;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start && ((state_q == IDLE) || (state_q == PAUSE))) begin
      dir_d = count_down;
      if (count_down && count_zero) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (tick_evt && (state_q == RUN)) begin
      if (dir_q) begin
        sec_dec = 1'b1;
        if (min_borrow && (sec_bcd == 8'h01)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else if (sec_carry && min_carry) begin
        cnt_clr = 1'b1;
      end else begin
        sec_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      tick_q     <= tick_in;
    end
  end

  bcd_mod_counter #(.MODULUS(60)) u_sec (
    .src_clk  (src_clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (load_sec),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .val      (sec_bcd),
    .carry    (sec_carry),
    .borrow   (sec_borrow)
  );

  bcd_mod_counter #(.MODULUS(MAX_MIN + 1)) u_min (
    .src_clk  (src_clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (load_min),
    .inc      (sec_inc & sec_carry),
    .dec      (sec_dec & sec_borrow),
    .val      (min_bcd),
    .carry    (min_carry),
    .borrow   (min_borrow)
  );

  assign running  = (state_q == RUN);
  assign tick_en  = running;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Scoreboard bench for tick_bcd_timer: directed scenarios plus random traffic vs. a seconds-total model.
module tb_tick_bcd_timer;

  localparam int MM   = 59;
  localparam int SPAN = (MM + 1) * 60;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       src_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic       count_down = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       tick_en, running, done, load_err;

  always #5 src_clk = ~src_clk;

  tick_bcd_timer #(.MAX_MIN(MM)) dut (
    .src_clk    (src_clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .load       (load),
    .count_down (count_down),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .tick_en    (tick_en),
    .running    (running),
    .done       (done),
    .load_err   (load_err)
  );

  typedef struct {
    logic [7:0] mn;
    logic [7:0] sc;
    logic       run;
    logic       dn;
    logic       le;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_pass = 0;
  logic tk_lvl = 1'b0;

  // Reference model: count kept as total seconds, mode as a plain integer.
  int m_mode = M_IDLE, m_total = 0;
  bit m_down = 1'b0, m_tq = 1'b0;
  bit m_pipe0 = 1'b0, m_pipe1 = 1'b0;

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic bit legal(input logic [7:0] b, input int mx);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd2i(b) <= mx);
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_total = 0; m_down = 1'b0; m_tq = 1'b0;
    m_pipe0 = 1'b0; m_pipe1 = 1'b0;
  endtask

  task automatic model_step(input logic cl, ld, sp, st, cd, input logic [7:0] lm, ls,
                            input logic tk, input string tag);
    bit   eff, evt;
    exp_t e;
    e.dn = 1'b0;
    e.le = 1'b0;
`ifdef TICK_SYNC_EN
    eff = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = tk;
`else
    eff = tk;
`endif
    evt  = eff && !m_tq;
    m_tq = eff;
    if (cl) begin
      m_mode = M_IDLE; m_total = 0;
    end else if (ld && m_mode != M_RUN) begin
      if (legal(lm, MM) && legal(ls, 59)) m_total = bcd2i(lm) * 60 + bcd2i(ls);
      else e.le = 1'b1;
    end else if (sp) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
      m_down = cd;
      if (cd && m_total == 0) begin m_mode = M_DONE; e.dn = 1'b1; end
      else m_mode = M_RUN;
    end else if (evt && m_mode == M_RUN) begin
      if (m_down) begin
        m_total = m_total - 1;
        if (m_total == 0) begin m_mode = M_DONE; e.dn = 1'b1; end
      end else begin
        m_total = (m_total + 1) % SPAN;
      end
    end
    e.mn  = i2bcd(m_total / 60);
    e.sc  = i2bcd(m_total % 60);
    e.run = (m_mode == M_RUN);
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic check(input string tag, input logic [7:0] amn, asc, input logic arun, aten, adn, ale,
                       input logic [7:0] emn, esc, input logic erun, edn, ele);
    n_chk++;
    if ({amn, asc, arun, aten, adn, ale} === {emn, esc, erun, erun, edn, ele}) n_pass++;
    else $display("FAIL %s: got %h:%h run=%b tick_en=%b done=%b load_err=%b, want %h:%h run=%b tick_en=%b done=%b load_err=%b",
                  tag, amn, asc, arun, aten, adn, ale, emn, esc, erun, erun, edn, ele);
  endtask

  task automatic drive(input logic cl, ld, sp, st, cd, input logic [7:0] lm, ls,
                       input logic tk, input string tag);
    @(negedge src_clk);
    clear = cl; load = ld; stop = sp; start = st; count_down = cd;
    load_min = lm; load_sec = ls; tick = tk; tk_lvl = tk;
    model_step(cl, ld, sp, st, cd, lm, ls, tk, tag);
  endtask

  task automatic nop(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00, 8'h00, tk_lvl, tag);
  endtask

  task automatic do_load(input logic [7:0] m, s, input string tag);
    drive(0, 1, 0, 0, 0, m, s, tk_lvl, tag);
  endtask

  task automatic do_start(input logic cd, input string tag);
    drive(0, 0, 0, 1, cd, 8'h00, 8'h00, tk_lvl, tag);
  endtask

  task automatic tick_pulse(input string tag);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b1, tag);
    nop(2, tag);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, tag);
    nop(2, tag);
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() > 0 && guard < 100) begin
      @(posedge src_clk);
      guard++;
    end
    #2;
    if (sbq.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
  endtask

  // Monitor: one scoreboard entry per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge src_clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.tag, min_bcd, sec_bcd, running, tick_en, done, load_err, e.mn, e.sc, e.run, e.dn, e.le);
      end
    end
  end

  initial begin
    logic [7:0] rm, rs;
    int r;
    m_reset();
    repeat (3) @(negedge src_clk);
    check("reset", min_bcd, sec_bcd, running, tick_en, done, load_err, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    nop(2, "idle");
    do_load(8'h00, 8'h58, "load_0058");
    do_start(1'b0, "start_up");
    for (int i = 0; i < 3; i++) tick_pulse("up_ticks");

    drive(0, 1, 0, 0, 0, 8'h12, 8'h34, 1'b0, "load_in_run");
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00, 1'b0, "stop");
    do_load(8'h01, 8'h00, "load_0100");
    do_start(1'b1, "start_down");
    for (int i = 0; i < 2; i++) tick_pulse("down_ticks");
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00, 1'b0, "stop2");
    do_load(8'h00, 8'h01, "load_0001");
    do_start(1'b1, "start_0001");
    tick_pulse("to_done");
    do_start(1'b0, "start_in_done");
    tick_pulse("tick_in_done");

    do_load(i2bcd(MM), 8'h59, "load_max");
    do_start(1'b0, "start_max");
    tick_pulse("wrap");
    tick_pulse("after_wrap");

    drive(0, 0, 1, 0, 0, 8'h00, 8'h00, 1'b1, "stop_and_tick");
    nop(3, "paused_tick_high");
    do_start(1'b0, "resume_tick_high");
    nop(3, "run_tick_high");
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, "tick_low");
    tick_pulse("resumed_tick");

    drive(0, 0, 1, 0, 0, 8'h00, 8'h00, 1'b0, "stop3");
    do_load(8'h1A, 8'h00, "bad_min");
    do_load(8'h00, 8'h60, "bad_sec");
    do_load(8'h60, 8'h00, "min_over_max");
    do_load(8'h00, 8'h30, "load_0030");
    drive(1, 0, 0, 1, 0, 8'h00, 8'h00, 1'b0, "clear_and_start");
    do_start(1'b1, "start_down_at_zero");
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, "clear_done");

    // Asynchronous reset in the middle of a run.
    do_load(8'h05, 8'h05, "load_0505");
    do_start(1'b0, "start_pre_rst");
    tick_pulse("pre_rst_tick");
    drain();
    @(posedge src_clk);
    #3 rst_n = 1'b0;
    #1 check("async_rst", min_bcd, sec_bcd, running, tick_en, done, load_err, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge src_clk);
    clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0; count_down = 1'b0; tick = 1'b0; tk_lvl = 1'b0;
    m_reset();
    rst_n = 1'b1;
    nop(2, "post_rst");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) tk_lvl = ~tk_lvl;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(1, 0, 0, 0, 0, 8'h00, 8'h00, tk_lvl, "rnd_clear");
      end else if (r < 8) begin
        if ($urandom_range(0, 1) == 1) begin
          rm = i2bcd($urandom_range(0, MM));
          rs = i2bcd($urandom_range(0, 59));
        end else begin
          rm = 8'($urandom);
          rs = 8'($urandom);
        end
        drive(0, 1, 0, 0, 0, rm, rs, tk_lvl, "rnd_load");
      end else if (r < 11) begin
        drive(0, 0, 1, 0, 0, 8'h00, 8'h00, tk_lvl, "rnd_stop");
      end else if (r < 18) begin
        drive(0, 0, 0, 1, 1'($urandom_range(0, 1)), 8'h00, 8'h00, tk_lvl, "rnd_start");
      end else begin
        drive(0, 0, 0, 0, 0, 8'h00, 8'h00, tk_lvl, "rnd_nop");
      end
    end

    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
